// File: rtl/risc_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : risc_data_mem_hs
// Purpose  : Word-organised data memory with a request/response handshake,
//            per-byte write strobes, registered single-cycle reads, address
//            checking and a hardware zero-fill sequencer.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            clear_req           - request a full zero-fill (taken in READY)
//            req_valid/req_ready - request handshake
//            req_we/req_addr     - write select and byte address
//            req_wdata/req_be    - write data and byte-lane enables
//            rsp_valid           - one-cycle response pulse
//            rsp_rdata/rsp_err   - read data / address-error flag
//            clearing            - zero-fill in progress
// Revision : 1.0 - initial release
// ============================================================================
module risc_data_mem_hs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              clearing
);

  localparam int OFS    = $clog2(BE_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_W - OFS;

  // Depth extended by one bit so the range compare never truncates.
  localparam logic [WIDX_W:0]  DEPTH_EXT = (WIDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clear_idx_q, clear_idx_d;
  logic                clear_pend_q, clear_pend_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [WIDX_W-1:0]   w_word_idx;
  logic [IDX_W-1:0]    w_mem_idx;
  logic                w_addr_err;
  logic                w_accept;
  logic                w_mem_clr;
  logic                w_mem_wr;

  // Out-of-range indices are never folded onto the array: the full word
  // index is compared, so aliasing low bits cannot hit a real word.
  assign w_word_idx = req_addr[ADDR_W-1:OFS];
  assign w_mem_idx  = w_word_idx[IDX_W-1:0];
  assign w_addr_err = (|req_addr[OFS-1:0]) || ({1'b0, w_word_idx} >= DEPTH_EXT);
  assign w_accept   = req_valid && (state_q == ST_READY);

  always_comb begin
    state_d      = state_q;
    clear_idx_d  = clear_idx_q;
    clear_pend_d = clear_pend_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    w_mem_clr    = 1'b0;
    w_mem_wr     = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        w_mem_clr   = 1'b1;
        clear_idx_d = clear_idx_q + IDX_ONE;
        if (clear_idx_q == IDX_LAST) begin
          state_d     = ST_READY;
          clear_idx_d = '0;
        end
      end
      ST_READY: begin
        if (w_accept) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = w_addr_err;
          w_mem_wr    = req_we && !w_addr_err;
          if (!req_we && !w_addr_err) begin
            rsp_rdata_d = mem[w_mem_idx];
          end
        end
        // A clear that collides with an accepted request is parked and
        // re-evaluated next cycle so the request still gets its response.
        if (clear_req || clear_pend_q) begin
          if (w_accept) begin
            clear_pend_d = 1'b1;
          end else begin
            state_d      = ST_CLEAR;
            clear_idx_d  = '0;
            clear_pend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clear_idx_q  <= '0;
      clear_pend_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      clear_pend_q <= clear_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Storage is not reset; the clear sequencer zero-fills it instead. Any
  // write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_mem_clr) begin
        mem[clear_idx_q] <= '0;
      end else if (w_mem_wr) begin
        for (int i = 0; i < BE_W; i++) begin
          if (req_be[i]) begin
            mem[w_mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign req_ready = (state_q == ST_READY);
  assign clearing  = (state_q == ST_CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_data_mem_hs
// Purpose  : Self-checking bench for risc_data_mem_hs using a word-array
//            reference model, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_data_mem_hs;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear_req;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              clearing;

  risc_data_mem_hs #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BE_W(BE_W)
  ) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .clearing(clearing)
  );

  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    foreach (model[i]) model[i] = 32'h0;
  endtask

  // One request; expected response computed from the address rules and
  // the model array, then the model is updated for writes.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input string tag);
    logic [31:0] exp_rd;
    bit          err;
    longint unsigned w;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_be = be;
    #1;
    check({tag, "_ready"}, req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    w   = longint'(addr) / 4;
    err = (addr % 4 != 0) || (w >= DEPTH);
    exp_rd = 32'h0;
    if (!err && !we) exp_rd = model[w];
    if (!err && we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[w][8*i +: 8] = data[8*i +: 8];
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_err"},   rsp_err,   err);
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
  endtask

  // Counts post-edge samples with clearing=1; also flags any ready or
  // response activity seen during the clear.
  task automatic count_clear(output int n, output int bad);
    n = 0; bad = 0;
    while (clearing === 1'b1 && n < 3000) begin
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_idle_valid"}, rsp_valid, 0);
    check({tag, "_idle_rdata"}, rsp_rdata, 0);
    check({tag, "_idle_err"},   rsp_err,   0);
  endtask

  initial begin
    int n, bad, r;
    logic [31:0] addr;

    reset = 1'b1; clear_req = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    model_zero();

    // Reset and initial clear with a read held pending the whole time.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    req_ready, 0);
    check("rst_valid",    rsp_valid, 0);
    check("rst_rdata",    rsp_rdata, 0);
    check("rst_err",      rsp_err,   0);
    check("rst_clearing", clearing,  1);
    reset = 1'b0;
    count_clear(n, bad);
    check("init_clear_len",   n,   DEPTH);
    check("init_clear_quiet", bad, 0);
    check("init_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("init_rd_valid", rsp_valid, 1);
    check("init_rd_err",   rsp_err,   0);
    check("init_rd_data",  rsp_rdata, 0);
    idle_check("init");

    // Full write then immediate read-back.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full");
    do_req(1'b0, 32'h10, 32'h0,        4'h0, "rd_full");
    check("rd_full_const", rsp_rdata, 32'hDEADBEEF);

    // Partial lanes over existing data.
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, "wr_part");
    do_req(1'b0, 32'h10, 32'h0,        4'h0,    "rd_part");
    check("rd_part_const", rsp_rdata, 32'hDE22BE44);

    // Misaligned and out-of-range.
    do_req(1'b0, 32'h12,   32'h0,        4'h0, "rd_misal");
    do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, "wr_oor");
    do_req(1'b0, 32'h0,    32'h0,        4'h0, "rd_zero");
    do_req(1'b1, 32'h14,   32'h12345678, 4'h0, "wr_nobe");

    // Random traffic within a small window for read-after-write hits.
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 11));
      addr = $urandom_range(0, 31) * 4;
      if (r == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (r == 1) addr = (32'd1024 + 32'($urandom_range(0, 2000))) << 2;
      else if (r == 2) addr = 32'($urandom_range(DEPTH - 4, DEPTH - 1)) * 4;
      if (r == 3) idle_check("rnd");
      do_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), "rnd");
    end

    // Clear request colliding with a write: response first, then the clear.
    @(negedge clk);
    clear_req = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_be = 4'hF;
    @(posedge clk);
    #1;
    clear_req = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    check("clr_wr_valid", rsp_valid, 1);
    check("clr_wr_err",   rsp_err,   0);
    check("clr_wr_rdata", rsp_rdata, 0);
    @(posedge clk);
    #1;
    count_clear(n, bad);
    check("clr_len",   n,   DEPTH);
    check("clr_quiet", bad, 0);
    model_zero();
    do_req(1'b0, 32'h20, 32'h0, 4'h0, "clr_rd20");
    do_req(1'b0, 32'h10, 32'h0, 4'h0, "clr_rd10");

    // Reset landing in the middle of a clear restarts it from the start.
    do_req(1'b1, 32'h40, 32'h0BADF00D, 4'hF, "pre_mid");
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    check("mid_clearing", clearing, 1);
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_clear(n, bad);
    check("mid_rst_len",   n,   DEPTH);
    check("mid_rst_quiet", bad, 0);
    model_zero();

    // Reset on the same edge as a request: no response, clear restarts.
    do_req(1'b1, 32'h40, 32'h55AA55AA, 4'hF, "pre_rst");
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0;
    check("rst_req_valid",    rsp_valid, 0);
    check("rst_req_clearing", clearing,  1);
    count_clear(n, bad);
    check("rst_req_len",   n,   DEPTH);
    check("rst_req_quiet", bad, 0);
    model_zero();
    do_req(1'b0, 32'h40, 32'h0, 4'h0, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
